// File: rtl/mutex_merge_pkg.sv
// Shared definitions for the mutually-exclusive merge: arbitration modes and
// the index-width helper used for ids, levels and pointers.
package mutex_merge_pkg;

  typedef enum logic {
    MM_MODE_FIXED = 1'b0,
    MM_MODE_RR    = 1'b1
  } mm_mode_e;

  // Width needed to index n items; never below one bit so ports stay legal.
  function automatic int mm_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mm_arbiter.sv
// Single-winner arbiter: fixed priority from channel 0, or round-robin search
// starting at ptr and wrapping from N-1 back to 0.
module mm_arbiter
  import mutex_merge_pkg::*;
#(
  parameter int       N    = 5,
  parameter mm_mode_e MODE = MM_MODE_RR,
  localparam int      IW   = mm_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int start;
    int ch;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    ch    = 0;
    start = (MODE == MM_MODE_RR) ? int'(ptr) : 0;
    for (int off = 0; off < N; off++) begin
      ch = (start + off) % N;
      if (!valid && req[ch]) begin
        valid     = 1'b1;
        grant[ch] = 1'b1;
        idx       = IW'(ch);
      end
    end
  end

endmodule

// File: rtl/mutex_merge_rr.sv
// Merges N requesting channels into one stream through a small FIFO; one
// channel is accepted per cycle and its id travels alongside the data.
module mutex_merge_rr
  import mutex_merge_pkg::*;
#(
  parameter int       N     = 5,
  parameter int       W     = 5,
  parameter int       DEPTH = 2,
  parameter mm_mode_e MODE  = MM_MODE_RR,
  localparam int      IW    = mm_width(N),
  localparam int      LW    = mm_width(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_drive,
  input  logic [N*W-1:0]  i_data,
  output logic [N-1:0]    o_free,
  output logic            o_driveNext,
  output logic [W-1:0]    o_data,
  output logic [IW-1:0]   o_id,
  input  logic            i_freeNext,
  output logic [LW-1:0]   o_level
);

  localparam int PW = mm_width(DEPTH);

  logic [W-1:0]  mem_data [DEPTH];
  logic [IW-1:0] mem_id   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] level;
  logic [IW-1:0] arb_ptr;

  logic [N-1:0]  grant;
  logic [IW-1:0] win_idx;
  logic          win_valid;
  logic [W-1:0]  win_data;
  logic          pop;
  logic          room;
  logic          push;

  mm_arbiter #(.N(N), .MODE(MODE)) u_arb (
    .req   (i_drive),
    .ptr   (arb_ptr),
    .grant (grant),
    .idx   (win_idx),
    .valid (win_valid)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop      = (level != '0) && i_freeNext;
  assign room     = (level < LW'(DEPTH)) || pop;
  // rst gates the grant so o_free is forced low asynchronously during reset
  assign push     = win_valid && room && rst;
  assign o_free   = push ? grant : '0;
  assign win_data = i_data[int'(win_idx)*W +: W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level   <= '0;
      arb_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= ptr_inc(wr_ptr);
        arb_ptr <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= win_data;
      mem_id[wr_ptr]   <= win_idx;
    end
  end

  assign o_level     = level;
  assign o_driveNext = (level != '0);
  assign o_data      = o_driveNext ? mem_data[rd_ptr] : '0;
  assign o_id        = o_driveNext ? mem_id[rd_ptr] : '0;

endmodule

// File: tb/tb_mutex_merge_rr.sv
// Scoreboard bench for mutex_merge_rr: a directed prologue followed by random
// traffic, checked against a queue-based model of arbitration and FIFO order.
module tb_mutex_merge_rr;
  import mutex_merge_pkg::*;

  localparam int N     = 5;
  localparam int W     = 5;
  localparam int DEPTH = 2;
  localparam int IW    = mm_width(N);
  localparam int LW    = mm_width(DEPTH + 1);

  typedef struct packed {
    logic [W-1:0]  d;
    logic [IW-1:0] id;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    i_drive = '0;
  logic [N*W-1:0]  i_data = '0;
  logic            i_freeNext = 1'b0;
  logic [N-1:0]    o_free;
  logic            o_driveNext;
  logic [W-1:0]    o_data;
  logic [IW-1:0]   o_id;
  logic [LW-1:0]   o_level;

  logic [N-1:0]    f_drive = '0;
  logic [N*W-1:0]  f_in_data = '0;
  logic            f_ready = 1'b1;
  logic [N-1:0]    f_free;
  logic            f_valid;
  logic [W-1:0]    f_data;
  logic [IW-1:0]   f_id;
  logic [LW-1:0]   f_level;

  int errors = 0;
  int checks = 0;
  entry_t exp_q[$];
  int ptr_m = 0;
  int level_m = 0;

  always #5 clk = ~clk;

  mutex_merge_rr #(.N(N), .W(W), .DEPTH(DEPTH), .MODE(MM_MODE_RR)) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data),
    .o_free(o_free), .o_driveNext(o_driveNext), .o_data(o_data),
    .o_id(o_id), .i_freeNext(i_freeNext), .o_level(o_level)
  );

  mutex_merge_rr #(.N(N), .W(W), .DEPTH(DEPTH), .MODE(MM_MODE_FIXED)) dut_fixed (
    .clk(clk), .rst(rst), .i_drive(f_drive), .i_data(f_in_data),
    .o_free(f_free), .o_driveNext(f_valid), .o_data(f_data),
    .o_id(f_id), .i_freeNext(f_ready), .o_level(f_level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requesting channel at or after p, wrapping.
  function automatic int model_winner(input logic [N-1:0] d, input int p);
    for (int i = 0; i < N; i++) begin
      if (d[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // One clock of stimulus: apply inputs, check the accept side, update model.
  task automatic cycle(input logic [N-1:0] drv, input logic [N*W-1:0] dat,
                       input logic rdy, output int g);
    logic [N-1:0] exp_free;
    bit pop_m, room_m;
    entry_t e;
    i_drive = drv;
    i_data = dat;
    i_freeNext = rdy;
    @(negedge clk);
    pop_m = (level_m > 0) && rdy;
    room_m = (level_m < DEPTH) || pop_m;
    g = room_m ? model_winner(drv, ptr_m) : -1;
    exp_free = '0;
    if (g >= 0) exp_free[g] = 1'b1;
    check("o_free", o_free, exp_free);
    check("onehot0", $onehot0(o_free), 1);
    check("o_level", o_level, level_m);
    check("o_driveNext", o_driveNext, level_m > 0);
    if (g >= 0) begin
      e.d = dat[g*W +: W];
      e.id = IW'(g);
      exp_q.push_back(e);
      ptr_m = (g + 1) % N;
    end
    level_m = level_m + ((g >= 0) ? 1 : 0) - (pop_m ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: head must match the oldest expected entry; pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (o_driveNext) begin
        if (exp_q.size() == 0) begin
          check("mon_unexpected_valid", 1, 0);
        end else begin
          check("mon_data", o_data, exp_q[0].d);
          check("mon_id", o_id, exp_q[0].id);
          if (i_freeNext) void'(exp_q.pop_front());
        end
      end else begin
        check("mon_idle_data", {o_data, o_id}, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    logic [N*W-1:0] dat;
    bit pend [N];
    logic [W-1:0] pdata [N];
    int wait_cnt [N];
    int exp_order [4] = '{0, 2, 4, 0};
    logic [N-1:0] drv;

    // Reset state, with a request present to prove o_free is gated.
    i_drive = 5'b00001;
    #3;
    check("rst_level", o_level, 0);
    check("rst_valid", o_driveNext, 0);
    check("rst_data", o_data, 0);
    check("rst_id", o_id, 0);
    check("rst_free", o_free, 0);
    i_drive = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fixed priority instance.
    for (int i = 0; i < 6; i++) begin
      f_drive = 5'b11000;
      @(negedge clk);
      check("fixed_grant_ch3", f_free, 5'b01000);
      if (i > 0) check("fixed_id", {f_valid, f_id}, {1'b1, IW'(3)});
      @(posedge clk);
      #1;
    end
    f_drive = 5'b10110;
    @(negedge clk);
    check("fixed_grant_ch1", f_free, 5'b00010);
    @(posedge clk);
    #1;
    f_drive = '0;
    @(negedge clk);
    check("fixed_idle", f_free, 0);
    @(posedge clk);
    #1;

    // Round-robin order over 10101.
    for (int k = 0; k < N; k++) dat[k*W +: W] = W'(k * 3 + 1);
    for (int i = 0; i < 4; i++) begin
      cycle(5'b10101, dat, 1'b1, g);
      check("rr_order", g, exp_order[i]);
    end
    for (int i = 0; i < 2; i++) cycle('0, '0, 1'b1, g);

    // Backpressure: fill, stall, then simultaneous pop and push.
    cycle(5'b00001, dat, 1'b0, g);
    check("bp_first", g, 0);
    cycle(5'b00001, dat, 1'b0, g);
    check("bp_second", g, 0);
    cycle(5'b00001, dat, 1'b0, g);
    check("bp_full_nogrant", g, -1);
    check("bp_level_full", o_level, 2);
    cycle(5'b00001, dat, 1'b1, g);
    check("bp_push_pop", g, 0);
    check("bp_level_held", o_level, 2);
    for (int i = 0; i < 3; i++) cycle('0, '0, 1'b1, g);

    // Wrap: ch3 leaves ptr at 4, so 00011 picks ch0 and then ch1.
    cycle(5'b01000, dat, 1'b1, g);
    check("wrap_ch3", g, 3);
    cycle(5'b00011, dat, 1'b1, g);
    check("wrap_ch0", g, 0);
    cycle(5'b00011, dat, 1'b1, g);
    check("wrap_ptr1_ch1", g, 1);
    for (int i = 0; i < 3; i++) cycle('0, '0, 1'b1, g);

    // Asynchronous reset mid-stream with a full buffer.
    cycle(5'b00001, dat, 1'b0, g);
    cycle(5'b00001, dat, 1'b0, g);
    check("pre_rst_level", o_level, 2);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_level", o_level, 0);
    check("async_rst_valid", o_driveNext, 0);
    check("async_rst_free", o_free, 0);
    exp_q.delete();
    level_m = 0;
    ptr_m = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    dat = '0;
    dat[2*W +: W] = 5'h1A;
    cycle(5'b00100, dat, 1'b0, g);
    check("post_rst_grant", g, 2);
    check("post_rst_head", {o_driveNext, o_data}, {1'b1, 5'h1A});
    cycle('0, '0, 1'b1, g);

    // Random traffic with held requests and fairness tracking.
    for (int k = 0; k < N; k++) begin
      pend[k] = 0;
      pdata[k] = '0;
      wait_cnt[k] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(2) == 0) begin
          pend[k] = 1;
          pdata[k] = W'($urandom);
        end
      end
      drv = '0;
      dat = '0;
      for (int k = 0; k < N; k++) begin
        drv[k] = pend[k];
        if (pend[k]) dat[k*W +: W] = pdata[k];
      end
      cycle(drv, dat, ($urandom_range(9) < 7), g);
      if (g >= 0) begin
        check("rr_fairness", wait_cnt[g] <= N - 1, 1);
        pend[g] = 0;
        wait_cnt[g] = 0;
        for (int k = 0; k < N; k++) if (pend[k]) wait_cnt[k]++;
      end
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle('0, '0, 1'b1, g);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_level", o_level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
